// File: rtl/led_pkg.sv
// Shared types for the LED pattern generator: mode encoding and BOUNCE direction state.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_SHL    = 2'd0,
    MODE_SHR    = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_FILL   = 2'd3
  } mode_e;

  typedef enum logic {
    BNC_UP   = 1'b0,
    BNC_DOWN = 1'b1
  } bounce_e;

endpackage

// File: rtl/led_prescaler.sv
// Step prescaler: counts enabled cycles and ticks once every step_div+1 of them.
module led_prescaler #(
  parameter int unsigned DIV_W = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic [DIV_W-1:0] step_div_i,
  output logic             tick_c
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // >= rather than == so a lowered step_div takes effect on the next enabled edge
  always_comb begin
    cnt_d  = cnt_q;
    tick_c = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      if (cnt_q >= step_div_i) begin
        tick_c = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator (SHL/SHR/BOUNCE/FILL) with registered step pulse.
// Optional brightness PWM on the LED drive is enabled by defining LED_PWM_EN.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int unsigned N_LED = 8,
  parameter int unsigned DIV_W = 24,
  parameter int unsigned PWM_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] step_div,
`ifdef LED_PWM_EN
  input  logic [PWM_W-1:0] duty,
`endif
  output logic [N_LED-1:0] leds,
  output logic             step
);

  if ((N_LED < 2) || (N_LED > 32) || (PWM_W < 1)) begin : g_bad_param
    $error("led_pattern_gen: illegal N_LED or PWM_W");
  end

  logic [N_LED-1:0] pattern_q, pattern_d;
  logic [N_LED-1:0] leds_q, leds_d;
  bounce_e          bounce_q, bounce_d;
  mode_e            mode_q, mode_d;
  logic             step_q, step_d;
  logic             mode_chg_c;
  logic             tick_c;

  assign mode_chg_c = (mode_e'(mode) != mode_q);

  led_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clock      (clock),
    .reset      (reset),
    .enable_i   (enable),
    .clear_i    (mode_chg_c),
    .step_div_i (step_div),
    .tick_c     (tick_c)
  );

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] pwm_q, pwm_d;
  assign pwm_d = pwm_q + PWM_W'(1);

  always_ff @(posedge clock) begin
    if (reset) pwm_q <= '0;
    else       pwm_q <= pwm_d;
  end
`endif

  // Next pattern; a mode change restarts the sequence and wins over a tick
  always_comb begin
    pattern_d = pattern_q;
    bounce_d  = bounce_q;
    mode_d    = mode_q;
    step_d    = 1'b0;
    if (mode_chg_c) begin
      pattern_d = N_LED'(1);
      bounce_d  = BNC_UP;
      mode_d    = mode_e'(mode);
    end else if (tick_c) begin
      step_d = 1'b1;
      case (mode_q)
        MODE_SHL: pattern_d = {pattern_q[N_LED-2:0], pattern_q[N_LED-1]};
        MODE_SHR: pattern_d = {pattern_q[0], pattern_q[N_LED-1:1]};
        MODE_BOUNCE: begin
          if (bounce_q == BNC_UP) begin
            if (pattern_q[N_LED-1]) begin
              bounce_d  = BNC_DOWN;
              pattern_d = pattern_q >> 1;
            end else begin
              pattern_d = pattern_q << 1;
            end
          end else begin
            if (pattern_q[0]) begin
              bounce_d  = BNC_UP;
              pattern_d = pattern_q << 1;
            end else begin
              pattern_d = pattern_q >> 1;
            end
          end
        end
        MODE_FILL: pattern_d = (&pattern_q) ? N_LED'(1) : {pattern_q[N_LED-2:0], 1'b1};
        default:   pattern_d = N_LED'(1);
      endcase
    end
`ifdef LED_PWM_EN
    leds_d = ((pwm_d < duty) || (&duty)) ? pattern_d : '0;
`else
    leds_d = pattern_d;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pattern_q <= N_LED'(1);
      leds_q    <= N_LED'(1);
      bounce_q  <= BNC_UP;
      mode_q    <= mode_e'(mode);
      step_q    <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      leds_q    <= leds_d;
      bounce_q  <= bounce_d;
      mode_q    <= mode_d;
      step_q    <= step_d;
    end
  end

  assign leds = leds_q;
  assign step = step_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed + random bench for led_pattern_gen with a position-based reference model.
// Define LED_PWM_EN to also exercise the brightness PWM.
module tb_led_pattern_gen;

  localparam int unsigned N_LED = 8;
  localparam int unsigned DIV_W = 24;
  localparam int unsigned PWM_W = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             enable;
  logic [1:0]       mode;
  logic [DIV_W-1:0] step_div;
`ifdef LED_PWM_EN
  logic [PWM_W-1:0] duty;
`endif
  logic [N_LED-1:0] leds;
  logic             step;

  always #5 clock = ~clock;

  led_pattern_gen #(.N_LED(N_LED), .DIV_W(DIV_W), .PWM_W(PWM_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .mode     (mode),
    .step_div (step_div),
`ifdef LED_PWM_EN
    .duty     (duty),
`endif
    .leds     (leds),
    .step     (step)
  );

  typedef struct packed {
    logic [N_LED-1:0] leds;
    logic             step;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: lit position / fill length rather than bit vectors
  int       m_pos, m_fill, m_cnt, m_pwm;
  bit       m_up, m_step, m_rst;
  logic [1:0] m_mode;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_restart();
    m_pos  = 0;
    m_up   = 1'b1;
    m_fill = 1;
    m_cnt  = 0;
    m_step = 1'b0;
    m_mode = mode;
  endtask

  task automatic m_advance();
    case (m_mode)
      2'd0: m_pos = (m_pos + 1) % N_LED;
      2'd1: m_pos = (m_pos + N_LED - 1) % N_LED;
      2'd2: begin
        if (m_up) begin
          if (m_pos == N_LED - 1) begin m_up = 1'b0; m_pos--; end
          else m_pos++;
        end else begin
          if (m_pos == 0) begin m_up = 1'b1; m_pos++; end
          else m_pos--;
        end
      end
      default: m_fill = (m_fill == N_LED) ? 1 : m_fill + 1;
    endcase
  endtask

  task automatic model_step();
    m_rst = reset;
    if (reset) begin
      m_restart();
      m_pwm = 0;
    end else begin
      m_pwm = (m_pwm + 1) % (1 << PWM_W);
      if (mode != m_mode) begin
        m_restart();
      end else if (enable && (m_cnt >= int'(step_div))) begin
        m_cnt  = 0;
        m_step = 1'b1;
        m_advance();
      end else begin
        if (enable) m_cnt++;
        m_step = 1'b0;
      end
    end
  endtask

  function automatic logic [N_LED-1:0] m_leds();
    logic [31:0] w;
    if (m_mode == 2'd3) w = (m_fill >= 32) ? 32'hFFFF_FFFF : ((32'd1 << m_fill) - 32'd1);
    else                w = 32'd1 << m_pos;
`ifdef LED_PWM_EN
    if (!m_rst && !((m_pwm < int'(duty)) || (duty == {PWM_W{1'b1}}))) w = '0;
`endif
    return N_LED'(w);
  endfunction

  // One clock: predict, push, let the edge happen, then pop and compare
  task automatic cycle(input string tag);
    exp_t e;
    model_step();
    e.leds = m_leds();
    e.step = m_step;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    e = sb_q.pop_front();
    chk({tag, ".leds"}, 32'(leds), 32'(e.leds));
    chk({tag, ".step"}, 32'(step), 32'(e.step));
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    mode     = 2'd0;
    step_div = '0;
`ifdef LED_PWM_EN
    duty     = '1;
`endif
    m_restart();
    m_pwm = 0;
    m_rst = 1'b1;

    repeat (2) cycle("reset");
    chk("reset_leds_const", 32'(leds), 32'h1);

    // SHL, tick every cycle
    reset  = 1'b0;
    enable = 1'b1;
    repeat (10) cycle("shl");

    // BOUNCE, step every 2 cycles, more than one full turn
    mode     = 2'd2;
    step_div = DIV_W'(1);
    repeat (34) cycle("bounce");

    // FILL held 3 cycles per step, then switch to SHR mid-run
    mode     = 2'd3;
    step_div = DIV_W'(2);
    repeat (28) cycle("fill");
    mode = 2'd1;
    cycle("mode_chg");
    chk("mode_chg_leds_const", 32'(leds), 32'h1);
    repeat (8) cycle("shr");

    // Lower step_div while counter sits at 7
    mode     = 2'd0;
    step_div = DIV_W'(9);
    cycle("div_restart");
    repeat (7) cycle("div_count");
    step_div = DIV_W'(3);
    cycle("div_lowered");
    chk("div_lowered_step_const", 32'(step), 32'h1);
    repeat (2) cycle("div_after");

    // Freeze with enable low
    enable = 1'b0;
    repeat (5) cycle("hold");
    enable = 1'b1;
    repeat (6) cycle("resume");

    // Reset mid-BOUNCE at leds=20
    mode     = 2'd2;
    step_div = '0;
    repeat (6) cycle("bounce2");
    chk("bounce_at_20", 32'(leds), 32'(m_leds()));
    reset = 1'b1;
    cycle("bounce_rst");
    reset = 1'b0;
    repeat (10) cycle("bounce_after_rst");

`ifdef LED_PWM_EN
    mode     = 2'd0;
    enable   = 1'b0;
    duty     = PWM_W'(4);
    repeat (32) cycle("pwm4");
    duty = '0;
    repeat (16) cycle("pwm0");
    duty = '1;
    repeat (16) cycle("pwm15");
    enable = 1'b1;
`endif

    // Random mix of modes, enables, divisors and resets
    for (int i = 0; i < 300; i++) begin
      enable   = ($urandom_range(0, 3) != 0);
      step_div = DIV_W'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      reset = ($urandom_range(0, 49) == 0);
`ifdef LED_PWM_EN
      if ($urandom_range(0, 15) == 0) duty = PWM_W'($urandom);
`endif
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 SHALL have parameter N_LED, default 8, number of LED channels (legal 2..32).
REQ-002 SHALL have parameter DIV_W, default 24, width of step_div.
REQ-003 SHALL have parameter PWM_W, default 4, width of duty and PWM counter.
REQ-004 SHALL have port clock  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  high: prescaler runs; low: prescaler and pattern hold.
REQ-007 SHALL have port mode  input  2  0 SHL, 1 SHR, 2 BOUNCE, 3 FILL.
REQ-008 SHALL have port step_div  input  DIV_W  step period minus one, in clock cycles.
REQ-009 SHALL have port duty  input  PWM_W  brightness; present only with LED_PWM_EN.
REQ-010 SHALL have port leds  output  N_LED  LED drive, bit0 = first LED.
REQ-011 SHALL have port step  output  1  one-cycle pulse per pattern advance.

Function
REQ-012 SHALL keep a prescaler counter that increments on each edge with enable=1 and counter < step_div.
REQ-013 SHALL generate a tick when enable=1 and counter >= step_div: counter goes to 0 and the pattern advances.
REQ-014 SHALL use >= so that lowering step_div mid-count ticks on the next enabled edge.
REQ-015 SHALL tick on every enabled edge when step_div=0; step period = step_div+1 cycles.
REQ-016 SHALL, in SHL, rotate the single lit bit toward the MSB on each tick, with bit N_LED-1 wrapping to bit0.
REQ-017 SHALL, in SHR, rotate the single lit bit toward the LSB on each tick, with bit0 wrapping to bit N_LED-1.
REQ-018 SHALL, in BOUNCE, run a two-state FSM UP/DOWN over lit position 0,1..N_LED-1,N_LED-2..1,0,1…
REQ-019 SHALL, in BOUNCE, switch UP->DOWN on the tick leaving position N_LED-1 and DOWN->UP on the tick leaving 0, with no end position repeated.
REQ-020 SHALL, in FILL, step the pattern 0..01, 0..011, …, all ones, then back to 0..01 (period N_LED ticks).
REQ-021 SHALL register mode into mode_q; on any edge where mode != mode_q, regardless of enable:
- pattern goes to 'h1
- FSM goes to UP
- counter goes to 0
- step goes to 0
- mode_q updates
REQ-022 SHALL give the mode-change action of REQ-021 priority over a simultaneous tick.
REQ-023 SHALL register step: it is high for exactly the one cycle in which a newly advanced pattern first appears on leds.
REQ-024 SHALL have the first change of leds after reset release (enable=1, constant mode) occur on the (step_div+1)th rising edge.

Reset
REQ-025 SHALL, on reset=1 at a rising edge, set pattern='h1, leds='h1, counter=0, FSM=UP, step=0, mode_q=mode, PWM counter=0.
REQ-026 SHALL give reset priority over enable, tick and mode change, and SHALL abort any step in progress.

Configuration
REQ-027 SHALL, with LED_PWM_EN defined:
- add the duty port and a free-running PWM_W-bit PWM counter
- drive leds = pattern when (pwm_cnt < duty) or duty is all ones; otherwise leds = 0
REQ-028 SHALL, with LED_PWM_EN undefined, have no duty port and no PWM logic, and leds = pattern.
REQ-029 SHALL leave pattern sequencing and step identical with and without LED_PWM_EN.

Structure
REQ-030 SHALL place the mode encoding (typedef with MODE_SHL/SHR/BOUNCE/FILL) and the BOUNCE FSM state typedef in shared package led_pkg.
REQ-031 SHALL implement the prescaler (counter, >= compare, tick) as sub-module led_prescaler, parameterised by DIV_W.

Verification
REQ-032 SHALL cover: N_LED=8, mode=0, step_div=0, enable=1 after reset -> leds 01,02,04,…,80,01; step high every cycle.
REQ-033 SHALL cover: mode=2, step_div=1 -> leds change every 2 cycles: 01,02,…,80,40,…,01,02; 80 and 01 each appear once per turn.
REQ-034 SHALL cover: mode=3, step_div=2 -> leds 01,03,07,…,FF,01 each held 3 cycles; mode switched to 1 mid-run -> leds=01 next edge and counter restarts.
REQ-035 SHALL cover: step_div=9, counter at 7, step_div changed to 3 -> tick on next enabled edge; enable=0 for 5 cycles -> leds and counter frozen, step=0.
REQ-036 SHALL cover: reset asserted mid-BOUNCE at leds=20 -> next edge leds=01, step=0, FSM=UP.
REQ-037 SHALL cover, with LED_PWM_EN: PWM_W=4, duty=4 -> leds equal pattern for 4 of every 16 cycles; duty=0 -> leds=0; duty=15 -> leds=pattern always.
